// File: rtl/model_matrix_stream_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : model_matrix_stream_receiver
//  Brief    : Consumer end of the row/element strobe protocol. Receives a
//             SIZE_I x SIZE_J matrix element by element, acknowledges each
//             element with registered strobes, stores it row-major in an
//             internal buffer and exposes the buffer on a synchronous read
//             port.
//  Revision : 1.0 - initial release
// ============================================================================
module model_matrix_stream_receiver #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64,
   parameter int ADDR_SIZE    = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic                 DATA_I_ENABLE,
   input  logic                 DATA_J_ENABLE,
   output logic                 DATA_OUT_I_ENABLE,
   output logic                 DATA_OUT_J_ENABLE,
   input  logic [DATA_SIZE-1:0] SIZE_I_IN,
   input  logic [DATA_SIZE-1:0] SIZE_J_IN,
   input  logic [DATA_SIZE-1:0] DATA_IN,
   input  logic [ADDR_SIZE-1:0] RD_ADDR,
   output logic [DATA_SIZE-1:0] RD_DATA,
   output logic                 ERROR,
   output logic [ADDR_SIZE:0]   COUNT
);

   // Counter width: large enough to hold 2^ADDR_SIZE itself.
   localparam int CW    = ADDR_SIZE + 1;
   localparam int DEPTH = 1 << ADDR_SIZE;

   localparam logic [DATA_SIZE-1:0] C_DEPTH_D = DATA_SIZE'(DEPTH);
   localparam logic [2*CW-1:0]      C_DEPTH_P = (2*CW)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ROW  = 2'd1,
      S_ELEM = 2'd2
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_size_i;
   logic [CW-1:0]        r_size_j;
   logic [CW-1:0]        r_i;
   logic [CW-1:0]        r_j;
   logic [DATA_SIZE-1:0] r_mem [0:DEPTH-1];

   logic [2*CW-1:0]      w_prod;
   logic                 w_size_bad;
   logic                 w_accept;
   logic                 w_violation;
   logic                 w_last_j;
   logic                 w_last_i;

   // The product only matters once both sizes passed the per-size bound,
   // so the low CW bits of each operand are sufficient and cannot overflow.
   assign w_prod = (2*CW)'(SIZE_I_IN[CW-1:0]) * (2*CW)'(SIZE_J_IN[CW-1:0]);

   assign w_size_bad = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) ||
                       (SIZE_I_IN > C_DEPTH_D) || (SIZE_J_IN > C_DEPTH_D) ||
                       (w_prod > C_DEPTH_P);

   // A START in the same cycle overrides any element strobe.
   assign w_accept = !START && DATA_J_ENABLE &&
                     (((r_state == S_ROW)  &&  DATA_I_ENABLE) ||
                      ((r_state == S_ELEM) && !DATA_I_ENABLE));

   assign w_violation = !START &&
                        (((r_state == S_ROW)  && DATA_J_ENABLE && !DATA_I_ENABLE) ||
                         ((r_state == S_ELEM) && DATA_I_ENABLE));

   assign w_last_j = (r_j == r_size_j - CW'(1));
   assign w_last_i = (r_i == r_size_i - CW'(1));

   // Reception control: size latch/check, element accept, acks and status.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state           <= S_IDLE;
         r_size_i          <= '0;
         r_size_j          <= '0;
         r_i               <= '0;
         r_j               <= '0;
         COUNT             <= '0;
         READY             <= 1'b0;
         ERROR             <= 1'b0;
         DATA_OUT_I_ENABLE <= 1'b0;
         DATA_OUT_J_ENABLE <= 1'b0;
      end else begin
         DATA_OUT_I_ENABLE <= 1'b0;
         DATA_OUT_J_ENABLE <= 1'b0;
         if (START) begin
            r_size_i <= SIZE_I_IN[CW-1:0];
            r_size_j <= SIZE_J_IN[CW-1:0];
            r_i      <= '0;
            r_j      <= '0;
            COUNT    <= '0;
            if (w_size_bad) begin
               ERROR   <= 1'b1;
               READY   <= 1'b1;
               r_state <= S_IDLE;
            end else begin
               ERROR   <= 1'b0;
               READY   <= 1'b0;
               r_state <= S_ROW;
            end
         end else if (w_accept) begin
            COUNT             <= COUNT + CW'(1);
            DATA_OUT_J_ENABLE <= 1'b1;
            if (w_last_j) begin
               r_j               <= '0;
               r_i               <= r_i + CW'(1);
               DATA_OUT_I_ENABLE <= 1'b1;
               if (w_last_i) begin
                  READY   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_ROW;
               end
            end else begin
               r_j     <= r_j + CW'(1);
               r_state <= S_ELEM;
            end
         end else if (w_violation) begin
            ERROR <= 1'b1;
         end
      end
   end

   // Buffer write; the write address always equals the elements written so far.
   always_ff @(posedge CLK) begin
      if (w_accept) begin
         r_mem[COUNT[ADDR_SIZE-1:0]] <= DATA_IN;
      end
   end

   // Synchronous read port; a same-cycle write is not bypassed (old data).
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         RD_DATA <= '0;
      end else begin
         RD_DATA <= r_mem[RD_ADDR];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_model_matrix_stream_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_model_matrix_stream_receiver
//  Brief    : Scoreboard bench for model_matrix_stream_receiver with a
//             behavioural reception model and randomized strobe traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_model_matrix_stream_receiver;

   localparam int DW    = 64;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          start    = 1'b0;
   logic          ie       = 1'b0;
   logic          je       = 1'b0;
   logic [DW-1:0] si_in    = '0;
   logic [DW-1:0] sj_in    = '0;
   logic [DW-1:0] din      = '0;
   logic [AW-1:0] rd_addr  = '0;
   logic          ready;
   logic          ack_i;
   logic          ack_j;
   logic          err;
   logic [DW-1:0] rd_data;
   logic [AW:0]   count;

   always #5 clk = ~clk;

   model_matrix_stream_receiver #(
      .DATA_SIZE(DW), .CONTROL_SIZE(64), .ADDR_SIZE(AW)
   ) dut (
      .CLK(clk), .RST(rst_n), .START(start), .READY(ready),
      .DATA_I_ENABLE(ie), .DATA_J_ENABLE(je),
      .DATA_OUT_I_ENABLE(ack_i), .DATA_OUT_J_ENABLE(ack_j),
      .SIZE_I_IN(si_in), .SIZE_J_IN(sj_in), .DATA_IN(din),
      .RD_ADDR(rd_addr), .RD_DATA(rd_data), .ERROR(err), .COUNT(count)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Scoreboard queues: expected ack (value = row-completed flag) and read data.
   bit            ack_q[$];
   logic [DW-1:0] rd_q[$];
   logic          rd_chk   = 1'b0;
   logic          rd_chk_q = 1'b0;

   // Reference model: element index k within the matrix, sizes, status flags.
   bit              m_active = 0;
   bit              m_err    = 0;
   bit              m_ready  = 0;
   longint unsigned m_si     = 0;
   longint unsigned m_sj     = 1;
   int              m_k      = 0;
   logic [DW-1:0]   m_mem [DEPTH];
   bit              m_wr  [DEPTH];

   task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents an ack or read data.
   always @(posedge clk) rd_chk_q <= rd_chk;

   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (rd_chk_q) begin
         check("rd_queue_nonempty", DW'(rd_q.size() != 0), DW'(1));
         if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            check("rd_data", rd_data, e);
         end
      end
      if (ack_j) begin
         check("ack_j_expected", DW'(ack_q.size() != 0), DW'(1));
         if (ack_q.size() != 0) check("ack_i", DW'(ack_i), DW'(ack_q.pop_front()));
      end else begin
         check("ack_i_alone", DW'(ack_i), DW'(ack_j));
      end
   end

   // One clock of stimulus; the model is advanced for the edge this cycle ends on.
   task automatic cyc(bit st, longint unsigned si, longint unsigned sj,
                      bit i_en, bit j_en, logic [DW-1:0] d, bit rchk, int ra);
      bit bad;
      bit row_start;
      start   = st;
      si_in   = si;
      sj_in   = sj;
      ie      = i_en;
      je      = j_en;
      din     = d;
      rd_addr = AW'(ra);
      rd_chk  = rchk && m_wr[ra];
      if (rd_chk) rd_q.push_back(m_mem[ra]);
      if (st) begin
         m_k = 0;
         if (si == 0 || sj == 0 || si > DEPTH || sj > DEPTH) bad = 1;
         else bad = (si * sj > DEPTH);
         m_err    = bad;
         m_ready  = bad;
         m_active = !bad;
         m_si     = si;
         m_sj     = sj;
      end else if (m_active) begin
         row_start = ((m_k % m_sj) == 0);
         if (j_en && (i_en == row_start)) begin
            m_mem[m_k] = d;
            m_wr[m_k]  = 1;
            ack_q.push_back(((m_k + 1) % m_sj) == 0);
            m_k++;
            if (m_k == m_si * m_sj) begin
               m_active = 0;
               m_ready  = 1;
            end
         end else if ((row_start && j_en && !i_en) || (!row_start && i_en)) begin
            m_err = 1;
         end
      end
      @(posedge clk);
      #1;
      check("ready", DW'(ready), DW'(m_ready));
      check("error", DW'(err),   DW'(m_err));
      check("count", DW'(count), DW'(m_k));
   endtask

   task automatic idle(int ra = 0, bit rchk = 0);
      cyc(0, 0, 0, 0, 0, '0, rchk, ra);
   endtask

   task automatic go(longint unsigned si, longint unsigned sj);
      cyc(1, si, sj, 0, 0, '0, 0, 0);
   endtask

   task automatic elem(bit i_en, logic [DW-1:0] d, int ra = 0, bit rchk = 0);
      cyc(0, 0, 0, i_en, 1, d, rchk, ra);
   endtask

   // Asynchronous reset pulse, applied after the monitor's sample point.
   task automatic pulse_reset();
      @(negedge clk);
      #1;
      start = 0; ie = 0; je = 0; rd_chk = 0;
      rst_n = 0;
      ack_q.delete();
      m_active = 0; m_err = 0; m_ready = 0; m_k = 0;
      #1;
      check("rst_ready", DW'(ready), DW'(0));
      check("rst_error", DW'(err),   DW'(0));
      check("rst_count", DW'(count), DW'(0));
      check("rst_ack_i", DW'(ack_i), DW'(0));
      check("rst_ack_j", DW'(ack_j), DW'(0));
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   // Whole matrix sent cleanly, then read back.
   task automatic clean_matrix(longint unsigned si, longint unsigned sj, logic [DW-1:0] base);
      go(si, sj);
      for (int k = 0; k < int'(si * sj); k++) elem((k % int'(sj)) == 0, base + DW'(k));
      idle();
      for (int k = 0; k < int'(si * sj); k++) idle(k, 1);
   endtask

   task automatic random_traffic(int runs);
      longint unsigned si;
      longint unsigned sj;
      int  sel;
      int  ra;
      bit  rs;
      bit  ie_r;
      bit  je_r;
      for (int r = 0; r < runs; r++) begin
         si = $urandom_range(1, 6);
         sj = $urandom_range(1, 6);
         if ($urandom_range(0, 9) == 0) si = 0;
         if ($urandom_range(0, 9) == 0) sj = $urandom_range(257, 300);
         go(si, sj);
         for (int c = 0; c < 200 && m_active; c++) begin
            sel = $urandom_range(0, 19);
            ra  = $urandom_range(0, 40);
            rs  = ((m_k % m_sj) == 0);
            if (sel < 14) begin
               ie_r = rs; je_r = 1;
            end else if (sel < 17) begin
               ie_r = 0; je_r = 0;
            end else begin
               ie_r = 1'($urandom_range(0, 1));
               je_r = 1'($urandom_range(0, 1));
            end
            if (sel == 19 && $urandom_range(0, 3) == 0)
               go($urandom_range(1, 5), $urandom_range(1, 5));
            else
               cyc(0, 0, 0, ie_r, je_r, {$urandom, $urandom}, 1, ra);
         end
         idle($urandom_range(0, 40), 1);
         idle($urandom_range(0, 40), 1);
      end
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         m_wr[a]  = 0;
         m_mem[a] = '0;
      end

      // Reset state
      #2;
      check("init_ready",   DW'(ready),   DW'(0));
      check("init_error",   DW'(err),     DW'(0));
      check("init_count",   DW'(count),   DW'(0));
      check("init_rd_data", rd_data,      DW'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1;
      idle();

      // 2x3 reception 10..15, read back
      clean_matrix(2, 3, 10);

      // Missing row marker, then recovery
      go(2, 2);
      elem(1, 1); elem(0, 2); elem(0, 3);
      elem(1, 3); elem(0, 4);
      idle();

      // Size rejections and boundaries
      go(0, 5);  idle();
      go(17, 16); idle();
      go(257, 1); idle();
      go(64'hFFFF_FFFF_FFFF_FFFF, 1); idle();
      go(1, 64'h1_0000_0001); idle();
      clean_matrix(1, 1, 64'hABCD);
      clean_matrix(16, 16, 64'h1000);
      clean_matrix(256, 1, 64'h5000);

      // Restart mid-stream
      go(3, 3);
      elem(1, 1); elem(0, 2); elem(0, 3); elem(1, 4);
      go(1, 2);
      elem(1, 7); elem(0, 8);
      idle(0, 1); idle(1, 1); idle();

      // Reset mid-stream: strobes ignored until START
      go(2, 2);
      elem(1, 21); elem(0, 22);
      pulse_reset();
      elem(1, 23); elem(0, 24); idle();

      // Read-during-write on the current write address
      go(1, 3);
      elem(1, 64'hAA, 0, 1);
      elem(0, 64'hBB, 1, 1);
      elem(0, 64'hCC, 1, 1);
      idle(2, 1); idle(2, 1);

      // Back-to-back element with a START in the same cycle as a strobe
      go(2, 2);
      elem(1, 31);
      cyc(1, 1, 1, 0, 1, 64'h99, 0, 0);
      elem(1, 41); idle(0, 1); idle();

      random_traffic(40);

      idle(); idle();
      check("ack_q_drained", DW'(ack_q.size()), DW'(0));
      check("rd_q_drained",  DW'(rd_q.size()),  DW'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/model_matrix_stream_receiver.md
Name: model_matrix_stream_receiver

Overview:
Consumer end of the row/element strobe protocol used to move matrices between stimulus and controller (the L/X and I/K enable pairs). It accepts a SIZE_I x SIZE_J matrix one element at a time on DATA_IN, qualified by DATA_I_ENABLE (first element of a row) and DATA_J_ENABLE (element valid). Each element is acknowledged with registered advance strobes and written row-major into an internal buffer. The buffer is then readable through a synchronous read port, so a bench or later pipeline stage can capture controller outputs such as W_OUT, K_OUT or H_OUT.

Parameters:
DATA_SIZE, 64, width of data and size words
CONTROL_SIZE, 64, width of control words (kept for interface uniformity, unused internally)
ADDR_SIZE, 8, buffer address width; depth = 2^ADDR_SIZE words

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
START  in  1  one-cycle pulse; latch sizes and begin a reception
READY  out  1  high when a reception completed or was rejected; low while receiving
DATA_I_ENABLE  in  1  marks the first element of a row
DATA_J_ENABLE  in  1  element valid
DATA_OUT_I_ENABLE  out  1  one-cycle ack: row completed, producer advances row index
DATA_OUT_J_ENABLE  out  1  one-cycle ack: element accepted, producer advances element index
SIZE_I_IN  in  DATA_SIZE  row count, sampled on START
SIZE_J_IN  in  DATA_SIZE  elements per row, sampled on START
DATA_IN  in  DATA_SIZE  element value
RD_ADDR  in  ADDR_SIZE  buffer read address
RD_DATA  out  DATA_SIZE  buffer read data, 1-cycle latency
ERROR  out  1  sticky protocol or size error; cleared by START
COUNT  out  ADDR_SIZE+1  number of elements written in the current or last reception

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; READY, ERROR, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE and RD_DATA = 0; COUNT = 0; i, j and address counters = 0. Buffer contents are undefined. A reset mid-reception aborts it with no ack pulses.
- States: IDLE, ROW (waiting for the first element of a row), ELEM (waiting for a subsequent element).
- Size check on START (any state): latch the sizes; clear ERROR, COUNT, i, j and addr; READY <= 0.
  - If SIZE_I_IN = 0, SIZE_J_IN = 0, either size > 2^ADDR_SIZE, or SIZE_I*SIZE_J > 2^ADDR_SIZE: ERROR <= 1, READY <= 1, go to IDLE.
  - The product is computed at 2*(ADDR_SIZE+1) bits after the per-size bound check, so it cannot overflow.
  - Otherwise go to ROW.
- START while in ROW or ELEM restarts the reception. Any element strobe in that same cycle is ignored.
- Accept in ROW: DATA_J_ENABLE=1 and DATA_I_ENABLE=1.
- Accept in ELEM: DATA_J_ENABLE=1 and DATA_I_ENABLE=0.
- On accept:
  - mem[addr] <= DATA_IN; addr++, COUNT++, j++.
  - DATA_OUT_J_ENABLE = 1 in the next cycle only.
  - If j = SIZE_J-1: j <= 0, i++, DATA_OUT_I_ENABLE = 1 in the next cycle, next state ROW; otherwise next state ELEM.
  - If the element is the last one (i = SIZE_I-1 and j = SIZE_J-1): READY <= 1, go to IDLE.
- Protocol violations set ERROR = 1 (sticky), drop the element, produce no ack, and leave state and counters unchanged:
  - DATA_J_ENABLE=1 with DATA_I_ENABLE=0 in ROW;
  - DATA_I_ENABLE=1 in ELEM.
- DATA_I_ENABLE=1 alone (DATA_J_ENABLE=0) is ignored in ROW and is an error in ELEM.
- In IDLE, element strobes are ignored; ERROR and READY are unchanged.
- Ack timing: acks are registered, so the producer may hold strobes for at most 1 cycle per element. Back-to-back elements every cycle are accepted.
- Read port: RD_DATA <= mem[RD_ADDR] every cycle, including during reception. A read and write to the same address in the same cycle returns the old data.
- COUNT holds its value in IDLE until the next START.
- Arithmetic is unsigned. Sizes are interpreted as unsigned DATA_SIZE integers.

Test Plan:
1. 2x3 reception: START with SIZE_I=2, SIZE_J=3; send 10..15, I_ENABLE on 10 and 13.
   -> DATA_OUT_J_ENABLE pulses 6 times and DATA_OUT_I_ENABLE pulses 2 times, each 1 cycle after elements 12 and 15.
   -> READY=1 the cycle after 15; COUNT=6; RD_ADDR=0..5 yields 10..15 with 1-cycle latency; ERROR=0.
2. Missing row marker: 2x2; send 1 with I_ENABLE, 2, then 3 without I_ENABLE.
   -> ERROR=1, no ack for 3, COUNT=2.
   -> Resend 3 with I_ENABLE, then 4: READY=1, COUNT=4, ERROR stays 1.
3. Size rejection: START with SIZE_I=0, SIZE_J=5 -> ERROR=1, READY=1 next cycle. START with 17x16 (272 > 256) -> ERROR=1, READY=1, COUNT=0.
4. Restart mid-stream: 3x3, send 4 elements, then START with 1x2 and send 7 (with I_ENABLE), 8.
   -> READY=1, COUNT=2, mem[0]=7, mem[1]=8, ERROR=0.
5. Reset mid-stream: 2x2, send 2 elements, pulse RST low for 1 cycle.
   -> READY, ERROR, COUNT and acks = 0 immediately (asynchronous); strobes are then ignored until START.
6. Read-during-write: during a reception, RD_ADDR equal to the write address -> old value returned; the new value appears on the following read.
